sdram_memtest: RTL and testbench

Self-checking SDRAM test sequencer that sits directly upstream of the SDRAM controller's system interface (addr/data/req/we in, ack/valid/q out). It writes a selectable data pattern to every word of the address space, reads every word back, compares it, and repeats for a programmed number of passes. It reports error count, first failing address and data, pass count and a handshake watchdog timeout for LEDs and diagnostic headers.

---
 rtl/sdram_memtest.sv | 244 ++++++++++++++++++++++++
 tb/tb_sdram_memtest.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_memtest.sv
// SDRAM test sequencer: writes a pattern to every word, reads it back, compares,
// and repeats for a number of passes while reporting errors, passes and watchdog timeouts.
module sdram_memtest #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        pattern,
    input  logic [7:0]        passes,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [31:0]       mem_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic [7:0]        pass_count
);
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, PASS_END, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         lfsr_reg;
    logic [1:0]          pattern_reg;
    logic [7:0]          passes_reg;
    logic [WD_W-1:0]     wd_reg;
    logic                gap_to_rd_reg;
    logic [15:0]         err_count_reg;
    logic                err_reg;
    logic                timeout_reg;
    logic [ADDR_W-1:0]   first_err_addr_reg;
    logic [31:0]         first_err_data_reg;
    logic [7:0]          pass_count_reg;

    logic                run_init, lfsr_adv, lfsr_load, addr_clr, addr_inc;
    logic                gap_set, gap_clr, do_cmp, pass_inc, wd_fire;
    logic [7:0]          seed_pc;
    logic [31:0]         expected_data;
    logic [15:0]         addr16;
    logic [4:0]          addr5;
    logic                addr_last, waiting, wd_expired;

    function automatic logic [31:0] lfsr_seed(input logic [7:0] pc);
        return {16'hACE1, 8'h00, pc} | 32'h1;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    assign addr16     = 16'(addr_reg);
    assign addr5      = 5'(addr_reg);
    assign addr_last  = &addr_reg;
    assign waiting    = (state_reg == WR_REQ) || (state_reg == RD_REQ) || (state_reg == RD_WAIT);
    assign wd_expired = (wd_reg >= WD_LAST);

    always_comb begin
        expected_data = 32'h0;
        case (pattern_reg)
            2'd0:    expected_data = {~addr16, addr16};
            2'd1:    expected_data = lfsr_reg;
            2'd2:    expected_data = 32'h1 << addr5;
            default: expected_data = {32{addr_reg[0]}};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        run_init   = 1'b0;
        lfsr_adv   = 1'b0;
        lfsr_load  = 1'b0;
        seed_pc    = pass_count_reg;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        gap_set    = 1'b0;
        gap_clr    = 1'b0;
        do_cmp     = 1'b0;
        pass_inc   = 1'b0;
        wd_fire    = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    run_init   = 1'b1;
                    state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    state_next = WR_GAP;
                    if (addr_last) begin
                        // reads replay the same LFSR sequence from the same seed
                        addr_clr  = 1'b1;
                        lfsr_load = 1'b1;
                        gap_set   = 1'b1;
                    end else begin
                        addr_inc = 1'b1;
                        lfsr_adv = 1'b1;
                    end
                end else if (wd_expired) begin
                    wd_fire    = 1'b1;
                    state_next = DONE;
                end
            end
            WR_GAP: state_next = gap_to_rd_reg ? RD_REQ : WR_REQ;
            RD_REQ: begin
                if (mem_ack) begin
                    if (mem_valid) begin
                        do_cmp   = 1'b1;
                        lfsr_adv = 1'b1;
                        if (addr_last) begin
                            state_next = PASS_END;
                        end else begin
                            addr_inc   = 1'b1;
                            state_next = RD_REQ;
                        end
                    end else begin
                        state_next = RD_WAIT;
                    end
                end else if (wd_expired) begin
                    wd_fire    = 1'b1;
                    state_next = DONE;
                end
            end
            RD_WAIT: begin
                if (mem_valid) begin
                    do_cmp   = 1'b1;
                    lfsr_adv = 1'b1;
                    if (addr_last) begin
                        state_next = PASS_END;
                    end else begin
                        addr_inc   = 1'b1;
                        state_next = RD_REQ;
                    end
                end else if (wd_expired) begin
                    wd_fire    = 1'b1;
                    state_next = DONE;
                end
            end
            PASS_END: begin
                pass_inc = 1'b1;
                gap_clr  = 1'b1;
                if (stop || (passes_reg != 8'd0 && pass_count_reg + 8'd1 == passes_reg)) begin
                    state_next = DONE;
                end else begin
                    state_next = WR_REQ;
                    addr_clr   = 1'b1;
                    lfsr_load  = 1'b1;
                    seed_pc    = pass_count_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            addr_reg           <= '0;
            lfsr_reg           <= '0;
            pattern_reg        <= '0;
            passes_reg         <= '0;
            wd_reg             <= '0;
            gap_to_rd_reg      <= 1'b0;
            err_count_reg      <= '0;
            err_reg            <= 1'b0;
            timeout_reg        <= 1'b0;
            first_err_addr_reg <= '0;
            first_err_data_reg <= '0;
            pass_count_reg     <= '0;
        end else begin
            state_reg <= state_next;
            // progress (state change or next read address) restarts the watchdog
            if (waiting && state_next == state_reg && !addr_inc)
                wd_reg <= wd_reg + WD_W'(1);
            else
                wd_reg <= '0;
            if (run_init) begin
                pattern_reg        <= pattern;
                passes_reg         <= passes;
                addr_reg           <= '0;
                lfsr_reg           <= lfsr_seed(8'd0);
                gap_to_rd_reg      <= 1'b0;
                err_count_reg      <= '0;
                err_reg            <= 1'b0;
                timeout_reg        <= 1'b0;
                first_err_addr_reg <= '0;
                first_err_data_reg <= '0;
                pass_count_reg     <= '0;
            end else begin
                if (lfsr_load)
                    lfsr_reg <= lfsr_seed(seed_pc);
                else if (lfsr_adv)
                    lfsr_reg <= lfsr_step(lfsr_reg);
                if (addr_clr)
                    addr_reg <= '0;
                else if (addr_inc)
                    addr_reg <= addr_reg + ADDR_W'(1);
                if (gap_set)
                    gap_to_rd_reg <= 1'b1;
                else if (gap_clr)
                    gap_to_rd_reg <= 1'b0;
                if (do_cmp && mem_q != expected_data) begin
                    err_reg <= 1'b1;
                    if (err_count_reg == 16'd0) begin
                        first_err_addr_reg <= addr_reg;
                        first_err_data_reg <= mem_q;
                    end
                    if (err_count_reg != 16'hFFFF)
                        err_count_reg <= err_count_reg + 16'd1;
                end
                if (pass_inc)
                    pass_count_reg <= pass_count_reg + 8'd1;
                if (wd_fire)
                    timeout_reg <= 1'b1;
            end
        end
    end

    assign mem_addr       = addr_reg;
    assign mem_req        = (state_reg == WR_REQ) || (state_reg == RD_REQ);
    assign mem_we         = (state_reg == WR_REQ);
    assign mem_data       = (state_reg == WR_REQ) ? expected_data : 32'h0;
    assign busy           = (state_reg != IDLE) && (state_reg != DONE);
    assign done           = (state_reg == DONE);
    assign err            = err_reg;
    assign timeout        = timeout_reg;
    assign err_count      = err_count_reg;
    assign first_err_addr = first_err_addr_reg;
    assign first_err_data = first_err_data_reg;
    assign pass_count     = pass_count_reg;
endmodule

// File: tb/tb_sdram_memtest.sv
// Directed bench for sdram_memtest: a small SDRAM model answers the system port
// and every result is compared against hand-computed values.
module tb_sdram_memtest;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [1:0]        pattern = 2'd0;
    logic [7:0]        passes = 8'd0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack = 1'b0;
    logic              mem_valid = 1'b0;
    logic [31:0]       mem_q = 32'h0;
    logic              busy, done, err, timeout;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [31:0]       first_err_data;
    logic [7:0]        pass_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdram_memtest #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .pattern(pattern), .passes(passes),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_q(mem_q),
        .busy(busy), .done(done), .err(err), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .pass_count(pass_count)
    );

    // SDRAM model: acks the first cycle req is high, returns read data vdelay cycles later
    logic [31:0] mem_model [0:15];
    logic [31:0] wr0_data [0:63];
    logic [31:0] wr1_data [0:63];
    int ack_en = 1;
    int vdelay = 3;
    int corrupt_addr = -1;
    int vcnt = 0;
    logic [31:0] vdata = 32'h0;
    int wr_cnt = 0, rd_cnt = 0, wr0_cnt = 0, wr1_cnt = 0;

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) begin
                mem_valid = 1'b1;
                mem_q     = vdata;
            end
        end
        if (mem_req && ack_en != 0) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                mem_model[mem_addr] = mem_data;
                wr_cnt++;
                if (mem_addr == 4'd0 && wr0_cnt < 64) begin wr0_data[wr0_cnt] = mem_data; wr0_cnt++; end
                if (mem_addr == 4'd1 && wr1_cnt < 64) begin wr1_data[wr1_cnt] = mem_data; wr1_cnt++; end
            end else begin
                rd_cnt++;
                vdata = mem_model[mem_addr] ^ ((int'(mem_addr) == corrupt_addr) ? 32'h1 : 32'h0);
                if (vdelay == 0) begin
                    mem_valid = 1'b1;
                    mem_q     = vdata;
                end else begin
                    vcnt = vdelay;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        if (obs === exp) $display("check %s: %h", tag, obs);
    endtask

    task automatic run(input logic [1:0] p, input logic [7:0] n);
        @(negedge clk);
        pattern = p;
        passes  = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
    endtask

    initial begin
        int wr_base, rd_base, w0_base, w1_base, req_cyc, i;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_errcnt", 32'(err_count), 32'h0);
        check("rst_pass", 32'(pass_count), 32'h0);
        reset = 1'b0;

        // pattern 0, one pass, ideal model
        wr_base = wr_cnt; rd_base = rd_cnt;
        run(2'd0, 8'd1);
        check("p0_busy", 32'(busy), 32'h1);
        wait_done("p0", 1000);
        check("p0_busy_end", 32'(busy), 32'h0);
        check("p0_errcnt", 32'(err_count), 32'h0);
        check("p0_err", 32'(err), 32'h0);
        check("p0_pass", 32'(pass_count), 32'h1);
        check("p0_writes", 32'(wr_cnt - wr_base), 32'd16);
        check("p0_reads", 32'(rd_cnt - rd_base), 32'd16);
        check("p0_mem5", mem_model[5], 32'hFFFA_0005);
        check("p0_mem15", mem_model[15], 32'hFFF0_000F);

        // same run with word 5 corrupted on readback
        corrupt_addr = 5;
        run(2'd0, 8'd1);
        wait_done("p0c", 1000);
        check("p0c_errcnt", 32'(err_count), 32'h1);
        check("p0c_err", 32'(err), 32'h1);
        check("p0c_faddr", 32'(first_err_addr), 32'h5);
        check("p0c_fdata", first_err_data, 32'hFFFA_0004);
        corrupt_addr = -1;

        // LFSR pattern, three passes
        wr_base = wr_cnt; w0_base = wr0_cnt; w1_base = wr1_cnt;
        run(2'd1, 8'd3);
        wait_done("lfsr", 3000);
        check("lfsr_errcnt", 32'(err_count), 32'h0);
        check("lfsr_pass", 32'(pass_count), 32'h3);
        check("lfsr_writes", 32'(wr_cnt - wr_base), 32'd48);
        check("lfsr_p1a0", wr0_data[w0_base], 32'hACE1_0001);
        check("lfsr_p1a1", wr1_data[w1_base], 32'h59C2_0003);
        check("lfsr_p2a0", wr0_data[w0_base + 1], 32'hACE1_0001);
        check("lfsr_p3a0", wr0_data[w0_base + 2], 32'hACE1_0003);

        // walking one with valid in the same cycle as ack
        vdelay = 0;
        rd_base = rd_cnt;
        run(2'd2, 8'd1);
        wait_done("walk", 1000);
        check("walk_errcnt", 32'(err_count), 32'h0);
        check("walk_mem3", mem_model[3], 32'h0000_0008);
        check("walk_mem15", mem_model[15], 32'h0000_8000);
        check("walk_reads", 32'(rd_cnt - rd_base), 32'd16);
        corrupt_addr = 7;
        run(2'd2, 8'd1);
        wait_done("walkc", 1000);
        check("walkc_errcnt", 32'(err_count), 32'h1);
        check("walkc_faddr", 32'(first_err_addr), 32'h7);
        check("walkc_fdata", first_err_data, 32'h0000_0081);
        corrupt_addr = -1;
        vdelay = 3;

        // no ack ever: watchdog
        ack_en = 0;
        run(2'd0, 8'd1);
        req_cyc = 0; i = 0;
        while (done !== 1'b1 && i < 200) begin
            if (mem_req) req_cyc++;
            @(negedge clk);
            i++;
        end
        check("wd_done", 32'(done), 32'h1);
        check("wd_timeout", 32'(timeout), 32'h1);
        check("wd_req", 32'(mem_req), 32'h0);
        check("wd_reqcyc", 32'(req_cyc), 32'(TIMEOUT));
        ack_en = 1;

        // run until stop, raised during pass 2; a start while busy is ignored
        run(2'd3, 8'd0);
        check("stop_tmo_clr", 32'(timeout), 32'h0);
        i = 0;
        while (pass_count !== 8'd1 && i < 2000) begin @(negedge clk); i++; end
        check("stop_pass1", 32'(pass_count), 32'h1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("stop_ign_start", 32'(pass_count), 32'h1);
        stop = 1'b1;
        wait_done("stop", 2000);
        stop = 1'b0;
        check("stop_pass", 32'(pass_count), 32'h2);
        check("stop_errcnt", 32'(err_count), 32'h0);
        check("stop_mem0", mem_model[0], 32'h0000_0000);
        check("stop_mem1", mem_model[1], 32'hFFFF_FFFF);

        // reset while waiting for read data; the late valid must be ignored
        corrupt_addr = 0;
        rd_base = rd_cnt;
        run(2'd0, 8'd1);
        i = 0;
        while (!(rd_cnt > rd_base && !mem_req && busy) && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("rst_rdwait_seen", 32'(i < 300), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_addr", 32'(mem_addr), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("late_errcnt", 32'(err_count), 32'h0);
        check("late_busy", 32'(busy), 32'h0);
        check("late_reads", 32'(rd_cnt - rd_base), 32'h1);
        corrupt_addr = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
